// File: rtl/bcd_pkg.sv
// Shared constants, state encoding and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam int unsigned MAX_DIGITS  = 10;
  localparam int unsigned BCD_MAX_W   = BCD_DIGIT_W * MAX_DIGITS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Leading-zero blank mask: bit k (k>=1) set iff digits k..digits-1 are all zero.
  // Bit 0 is never set so a value of zero still shows a single '0'.
  function automatic logic [MAX_DIGITS-1:0] bcd_blank_mask(
    input logic [BCD_MAX_W-1:0] bcd,
    input int unsigned          digits
  );
    logic [MAX_DIGITS-1:0] mask;
    logic                  zero_above;
    mask       = '0;
    zero_above = 1'b1;
    for (int k = int'(MAX_DIGITS) - 1; k >= 1; k--) begin
      if (k < int'(digits)) begin
        zero_above = zero_above & (bcd[k*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'd0);
        mask[k]    = zero_above;
      end
    end
    return mask;
  endfunction

endpackage : bcd_pkg

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction cell: a digit of 5 or more gets +3 so the following
// left shift carries correctly into the next decimal digit.
//   din   in   4   working BCD digit (0..9)
//   dout  out  4   adjusted digit (0..4 or 8..12), combinational
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);

  always_comb begin
    dout = din;
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end
  end

endmodule : bcd_digit_adj

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Produces packed BCD digits, a leading-zero blank mask and an overflow flag.
//   clk       in   1          clock, rising edge
//   rst       in   1          asynchronous active-high reset
//   start     in   1          conversion request, honoured only while idle
//   bin       in   BIN_W      value captured on accepted start
//   busy      out  1          conversion in progress
//   done      out  1          single-cycle pulse when bcd/blank/overflow update
//   bcd       out  4*DIGITS   packed digits, ones at [3:0]
//   blank     out  DIGITS     leading-zero mask, bit0 never set
//   overflow  out  1          last result did not fit in DIGITS digits
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 14,
  parameter int unsigned DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [BIN_W-1:0]              bin,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic [DIGITS-1:0]             blank,
  output logic                          overflow
);

  localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  state_t             state,     state_nxt;
  logic [BIN_W-1:0]   shreg,     shreg_nxt;
  logic [BCD_W-1:0]   work,      work_nxt;
  logic [CNT_W-1:0]   cnt,       cnt_nxt;
  logic               sticky,    sticky_nxt;
  logic               busy_nxt,  done_nxt, ovf_nxt;
  logic [BCD_W-1:0]   bcd_nxt;
  logic [DIGITS-1:0]  blank_nxt;
  logic [BCD_W-1:0]   work_adj;

  // One add-3 correction cell per working digit.
  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (work    [g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dout (work_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      work     <= '0;
      cnt      <= '0;
      sticky   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      blank    <= BLANK_RST;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      work     <= work_nxt;
      cnt      <= cnt_nxt;
      sticky   <= sticky_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      bcd      <= bcd_nxt;
      blank    <= blank_nxt;
      overflow <= ovf_nxt;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_nxt  = state;
    shreg_nxt  = shreg;
    work_nxt   = work;
    cnt_nxt    = cnt;
    sticky_nxt = sticky;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    bcd_nxt    = bcd;
    blank_nxt  = blank;
    ovf_nxt    = overflow;

    case (state)
      ST_IDLE: begin
        if (start) begin
          shreg_nxt  = bin;
          work_nxt   = '0;
          cnt_nxt    = CNT_W'(BIN_W);
          sticky_nxt = 1'b0;
          busy_nxt   = 1'b1;
          state_nxt  = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        // Adjusted digits shift left with the next binary bit entering digit0;
        // the bit leaving the top digit is a lost decimal carry.
        {work_nxt, shreg_nxt} = {work_adj[BCD_W-2:0], shreg, 1'b0};
        sticky_nxt            = sticky | work_adj[BCD_W-1];
        cnt_nxt               = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_nxt = ST_DONE;
        end
      end

      ST_DONE: begin
        bcd_nxt   = work;
        ovf_nxt   = sticky;
        blank_nxt = sticky ? '0 : DIGITS'(bcd_blank_mask(BCD_MAX_W'(work), DIGITS));
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end

      default: begin
        busy_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule : bin_to_bcd_seq

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: directed corner cases plus randomized
// conversions compared against a decimal-arithmetic reference model.
module tb_bin_to_bcd_seq;

  localparam int unsigned BW  = 14;
  localparam int unsigned DG  = 4;
  localparam int unsigned BW2 = 20;
  localparam int unsigned DG2 = 6;

  logic              clk;
  logic              rst;
  logic              start;
  logic [BW-1:0]     bin;
  logic              busy, done, overflow;
  logic [4*DG-1:0]   bcd;
  logic [DG-1:0]     blank;

  logic              start2;
  logic [BW2-1:0]    bin2;
  logic              busy2, done2, overflow2;
  logic [4*DG2-1:0]  bcd2;
  logic [DG2-1:0]    blank2;

  int total = 0;
  int bad   = 0;

  bin_to_bcd_seq #(.BIN_W(BW), .DIGITS(DG)) dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin), .busy(busy), .done(done),
    .bcd(bcd), .blank(blank), .overflow(overflow)
  );

  bin_to_bcd_seq #(.BIN_W(BW2), .DIGITS(DG2)) dut_wide (
    .clk(clk), .rst(rst), .start(start2), .bin(bin2), .busy(busy2), .done(done2),
    .bcd(bcd2), .blank(blank2), .overflow(overflow2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: decimal digits of v mod 10^d, overflow when v needs more than d digits.
  function automatic void model(input longint unsigned v, input int d,
                                output logic [63:0] b, output logic [15:0] bl,
                                output logic ov);
    longint unsigned lim = 1;
    longint unsigned m;
    longint unsigned p = 10;
    for (int i = 0; i < d; i++) lim = lim * 10;
    ov = (v >= lim);
    m  = v % lim;
    b  = '0;
    for (int i = 0; i < d; i++) begin
      b[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    bl = '0;
    for (int k = 1; k < d; k++) begin
      bl[k] = !ov && ((v % lim) < p);
      p = p * 10;
    end
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Starts at a negedge, ends at the negedge of the done cycle.
  // With noise set, start and bin toggle randomly while the conversion runs.
  task automatic run_conv(input logic [BW-1:0] v, input bit noise);
    logic [63:0] eb;
    logic [15:0] ebl;
    logic        eov;
    int          n;
    bit          busy_ok;
    start = 1'b1;
    bin   = v;
    @(posedge clk);
    @(negedge clk);
    start   = 1'b0;
    busy_ok = (busy === 1'b1);
    n       = 0;
    while (n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (done === 1'b1) break;
      busy_ok = busy_ok && (busy === 1'b1);
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        bin   = BW'($urandom);
      end
    end
    start = 1'b0;
    model(64'(v), int'(DG), eb, ebl, eov);
    chk("latency", 64'(n), 64'(BW + 1));
    chk("busy_run", 64'(busy_ok), 64'd1);
    chk("busy_in_done", 64'(busy), 64'd0);
    chk("bcd", 64'(bcd), eb);
    chk("blank", 64'(blank), 64'(ebl[DG-1:0]));
    chk("overflow", 64'(overflow), 64'(eov));
  endtask

  logic [BW-1:0] corner [11];
  logic [63:0]   eb2;
  logic [15:0]   ebl2;
  logic          eov2;
  int            n2;
  bit            saw_done;

  initial begin
    corner = '{14'd0, 14'd1, 14'd9, 14'd10, 14'd99, 14'd100, 14'd999,
               14'd1000, 14'd9999, 14'd10000, 14'd16383};
    rst    = 1'b1;
    start  = 1'b0;
    bin    = '0;
    start2 = 1'b0;
    bin2   = '0;
    idle(2);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_bcd", 64'(bcd), 64'd0);
    chk("rst_blank", 64'(blank), 64'b1110);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_blank_wide", 64'(blank2), 64'b111110);
    rst = 1'b0;
    idle(1);

    // Directed cases, including overflow followed by a clean conversion.
    run_conv(14'd0, 1'b0);
    chk("zero_bcd", 64'(bcd), 64'h0000);
    chk("zero_blank", 64'(blank), 64'b1110);
    idle(1);
    run_conv(14'd128, 1'b0);
    chk("d128_bcd", 64'(bcd), 64'h0128);
    chk("d128_blank", 64'(blank), 64'b1000);
    run_conv(14'd9999, 1'b0);
    chk("d9999_bcd", 64'(bcd), 64'h9999);
    run_conv(14'd16383, 1'b0);
    chk("d16383_bcd", 64'(bcd), 64'h6383);
    chk("d16383_ovf", 64'(overflow), 64'd1);
    chk("d16383_blank", 64'(blank), 64'b0000);
    run_conv(14'd5, 1'b0);
    chk("d5_bcd", 64'(bcd), 64'h0005);
    chk("d5_ovf", 64'(overflow), 64'd0);
    chk("d5_blank", 64'(blank), 64'b1110);

    // Start/bin noise while busy, then back-to-back start in the done cycle.
    idle(2);
    run_conv(14'd42, 1'b1);
    chk("d42_bcd", 64'(bcd), 64'h0042);
    run_conv(14'd77, 1'b0);
    chk("d77_bcd", 64'(bcd), 64'h0077);

    // Corner values followed by random values, with random idle gaps and noise.
    for (int i = 0; i < 40; i++) begin
      if (i < 11) run_conv(corner[i], 1'b0);
      else        run_conv(BW'($urandom_range(0, 16383)), 1'($urandom_range(0, 1)));
      idle($urandom_range(0, 2));
    end

    // Wide instance: 20-bit full scale into six digits.
    start2 = 1'b1;
    bin2   = 20'd1048575;
    @(posedge clk);
    @(negedge clk);
    start2 = 1'b0;
    n2     = 0;
    while (n2 < 60) begin
      @(posedge clk);
      n2++;
      @(negedge clk);
      if (done2 === 1'b1) break;
    end
    model(64'd1048575, int'(DG2), eb2, ebl2, eov2);
    chk("wide_latency", 64'(n2), 64'(BW2 + 1));
    chk("wide_bcd", 64'(bcd2), eb2);
    chk("wide_bcd_lit", 64'(bcd2), 64'h048575);
    chk("wide_blank", 64'(blank2), 64'(ebl2[DG2-1:0]));
    chk("wide_ovf", 64'(overflow2), 64'(eov2));

    // Reset five cycles into a conversion: abort, outputs back to reset values.
    run_conv(14'd321, 1'b0);
    start = 1'b1;
    bin   = 14'd1234;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    idle(5);
    rst = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_bcd", 64'(bcd), 64'd0);
    chk("abort_blank", 64'(blank), 64'b1110);
    chk("abort_ovf", 64'(overflow), 64'd0);
    idle(1);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    chk("abort_no_done", 64'(saw_done), 64'd0);
    chk("abort_hold_bcd", 64'(bcd), 64'd0);
    run_conv(14'd1234, 1'b0);
    chk("after_abort_bcd", 64'(bcd), 64'h1234);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_bin_to_bcd_seq
